// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM states and engine modes shared by alu_seq
package alu_pkg;

    localparam logic [2:0] OP_XOR = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_REM = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } md_mode_t;

    // Division by zero short-circuits to a fixed result, so only a real divide iterates.
    function automatic logic is_iter_op(input logic [2:0] op, input logic b_zero);
        return (op == OP_MUL) || (((op == OP_DIV) || (op == OP_REM)) && !b_zero);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - shared shift engine: shift-add multiply, restoring divide
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  md_mode_t         mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   opnd;
    md_mode_t           mode_q;
    logic [CNT_W-1:0]   cnt;
    logic               run;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;

    // acc = {hi, lo}: MUL keeps partial product in hi and the unconsumed multiplier in lo;
    // DIV keeps the partial remainder in hi and shifts quotient bits into lo.
    always_comb begin
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd & {WIDTH{acc[0]}}};
        trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        if (mode_q == MODE_MUL) begin
            acc_nxt = {sum, acc[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
        end
    end

    // The final step is exposed before it lands so the owner can register it on the done edge.
    assign done   = run && (cnt == LAST);
    assign res_lo = acc_nxt[WIDTH-1:0];
    assign res_hi = acc_nxt[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            run    <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            mode_q <= MODE_MUL;
        end else if (start) begin
            run    <= 1'b1;
            cnt    <= '0;
            acc    <= {{WIDTH{1'b0}}, a};
            opnd   <= b;
            mode_q <= mode;
        end else if (run) begin
            acc <= acc_nxt;
            if (done) begin
                run <= 1'b0;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with valid/ready handshake and registered result/flags
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z_f,
    output logic             o_f,
    output logic             c_f,
    output logic             dz_f,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       op_q;
    logic             accept;
    logic             b_zero;
    logic             start_iter;
    md_mode_t         md_mode;
    logic             md_done;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] sc_result;
    logic             sc_o;
    logic             sc_c;
    logic             sc_dz;
    logic [WIDTH-1:0] calc_result;
    logic             calc_o;

    assign in_ready   = (state == S_IDLE);
    assign busy       = (state == S_CALC);
    assign out_valid  = (state == S_DONE);
    assign accept     = in_valid && in_ready;
    assign b_zero     = (b_in == '0);
    assign start_iter = accept && is_iter_op(sel, b_zero);
    assign md_mode    = (sel == OP_MUL) ? MODE_MUL : MODE_DIV;

    alu_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (start_iter),
        .mode   (md_mode),
        .a      (a_in),
        .b      (b_in),
        .done   (md_done),
        .res_lo (md_lo),
        .res_hi (md_hi)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = start_iter ? S_CALC : S_DONE;
            S_CALC:  if (md_done) state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Subtraction as a + ~b + 1, so no carry out means a borrow.
    always_comb begin
        add_full  = {1'b0, a_in} + {1'b0, b_in};
        sub_full  = {1'b0, a_in} + {1'b0, ~b_in} + 1'b1;
        sc_result = '0;
        sc_o      = 1'b0;
        sc_c      = 1'b0;
        sc_dz     = 1'b0;
        case (sel)
            OP_XOR: sc_result = a_in ^ b_in;
            OP_AND: sc_result = a_in & b_in;
            OP_OR:  sc_result = a_in | b_in;
            OP_ADD: begin
                sc_result = add_full[WIDTH-1:0];
                sc_c      = add_full[WIDTH];
                sc_o      = (a_in[WIDTH-1] == b_in[WIDTH-1]) &&
                            (add_full[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = sub_full[WIDTH-1:0];
                sc_c      = !sub_full[WIDTH];
                sc_o      = (a_in[WIDTH-1] != b_in[WIDTH-1]) &&
                            (sub_full[WIDTH-1] != a_in[WIDTH-1]);
            end
            // Only reached with a zero divisor; nonzero divisors go to the engine.
            OP_DIV: begin
                sc_result = '1;
                sc_dz     = 1'b1;
            end
            OP_REM: begin
                sc_result = a_in;
                sc_dz     = 1'b1;
            end
            default: sc_result = '0;
        endcase
    end

    always_comb begin
        calc_result = md_lo;
        calc_o      = 1'b0;
        if (op_q == OP_MUL) begin
            calc_o = |md_hi;
        end else if (op_q == OP_REM) begin
            calc_result = md_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= OP_XOR;
            result <= '0;
            z_f    <= 1'b0;
            o_f    <= 1'b0;
            c_f    <= 1'b0;
            dz_f   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) op_q <= sel;
            if (accept && !start_iter) begin
                result <= sc_result;
                z_f    <= (sc_result == '0);
                o_f    <= sc_o;
                c_f    <= sc_c;
                dz_f   <= sc_dz;
            end else if (busy && md_done) begin
                result <= calc_result;
                z_f    <= (calc_result == '0);
                o_f    <= calc_o;
                c_f    <= 1'b0;
                dz_f   <= 1'b0;
            end
        end
    end

endmodule
